// File: rtl/sag_scatter_seq_if.sv
// Handshake bundle between the SAG scatter sequencer and its neighbours.
// The master side feeds packed words in and drains scattered words out.
interface sag_scatter_seq_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] in_ctrl;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [W-1:0] out_ctrl;
    logic         busy;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, busy
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, busy
    );
endinterface

// File: rtl/sag_scatter_seq.sv
// Bit-serial inverse of the sheep-and-goats gather: rebuilds d from packed y and mask c,
// one result bit per clock, with valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for an input word, in_ready=1
// RUN   | scattering bit idx of the result, inputs ignored
// DONE  | result presented on out_data/out_ctrl until out_ready
module sag_scatter_seq #(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst,
    sag_scatter_seq_if.slave  bus
);
    localparam int LW = $clog2(W);
    localparam logic [LW-1:0] LAST = LW'(W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  y_q;
    logic [W-1:0]  c_q;
    logic [W-1:0]  d_q;
    logic [LW-1:0] idx;
    logic [LW:0]   p1;
    logic [LW-1:0] p0;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            y_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            idx         <= '0;
            p1          <= '0;
            p0          <= LAST;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        y_q        <= bus.in_data;
                        c_q        <= bus.in_ctrl;
                        d_q        <= '0;
                        idx        <= '0;
                        p1         <= '0;
                        p0         <= LAST;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    // Set mask bits draw from the low end of y, clear bits from the high end.
                    if (c_q[idx]) begin
                        d_q[idx] <= y_q[p1[LW-1:0]];
                        p1       <= p1 + 1'b1;
                    end else begin
                        d_q[idx] <= y_q[p0];
                        if (p0 != '0) p0 <= p0 - 1'b1;
                    end
                    if (idx == LAST) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // A new word can only be taken one cycle later, from IDLE.
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = d_q;
    assign bus.out_ctrl  = c_q;
    assign bus.busy      = busy_q;
endmodule
